// File: rtl/debouncer_pkg.sv
// Shared types and compile-time helpers for the multi-channel key debouncer.
package debouncer_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_CONF_PRESS,
        ST_PRESSED,
        ST_CONF_RELEASE
    } deb_state_t;

    // Rounds up so a requested time is never undershot; never returns less than one cycle.
    function automatic int cycles_from_ns(input int ns, input int mhz);
        longint c;
        c = (longint'(ns) * longint'(mhz) + 64'd999) / 64'd1000;
        return (c < 1) ? 1 : int'(c);
    endfunction

    function automatic int cnt_width(input int max_cnt);
        return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/debouncer_channel.sv
// One debounced key: 2-FF synchroniser, qualification FSM, level and strobe registers.
// Long-press strobe exists only when DEBOUNCER_MULTI_LONG_PRESS_EN is defined.
//
// state           | meaning
// ST_RELEASED     | key accepted as released, waiting for a press sample
// ST_CONF_PRESS   | press seen, counting stable cycles before accepting
// ST_PRESSED      | key accepted as pressed (long-press timer runs here)
// ST_CONF_RELEASE | release seen, counting stable cycles; level still reads pressed
module debouncer_channel
    import debouncer_pkg::*;
#(
    parameter int G          = 1,
    parameter int CNT_W      = 1,
`ifdef DEBOUNCER_MULTI_LONG_PRESS_EN
    parameter int L          = 1,
`endif
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic key_state_o,
    output logic key_pressed_stb_o,
    output logic key_released_stb_o,
    output logic key_long_stb_o
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_CONF = CNT_W'(G - 1);
`ifdef DEBOUNCER_MULTI_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] CNT_LONG = CNT_W'(L);
    logic                        long_done_q;
`endif

    logic [1:0]       sync_q;
    deb_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             s;

    assign s = sync_q[1] ^ ACTIVE_LOW;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q             <= {2{ACTIVE_LOW}};
            state_q            <= ST_RELEASED;
            cnt_q              <= '0;
            key_state_o        <= 1'b0;
            key_pressed_stb_o  <= 1'b0;
            key_released_stb_o <= 1'b0;
`ifdef DEBOUNCER_MULTI_LONG_PRESS_EN
            key_long_stb_o     <= 1'b0;
            long_done_q        <= 1'b0;
`endif
        end else begin
            sync_q             <= {sync_q[0], key_i};
            key_pressed_stb_o  <= 1'b0;
            key_released_stb_o <= 1'b0;
`ifdef DEBOUNCER_MULTI_LONG_PRESS_EN
            key_long_stb_o     <= 1'b0;
            if (state_q == ST_RELEASED) long_done_q <= 1'b0;
`endif
            case (state_q)
                ST_RELEASED: begin
                    if (s) begin
                        if (G == 1) begin
                            state_q           <= ST_PRESSED;
                            cnt_q             <= '0;
                            key_state_o       <= 1'b1;
                            key_pressed_stb_o <= 1'b1;
                        end else begin
                            state_q <= ST_CONF_PRESS;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                ST_CONF_PRESS: begin
                    if (!s) begin
                        state_q <= ST_RELEASED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_CONF) begin
                        state_q           <= ST_PRESSED;
                        cnt_q             <= '0;
                        key_state_o       <= 1'b1;
                        key_pressed_stb_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (!s) begin
                        if (G == 1) begin
                            state_q            <= ST_RELEASED;
                            cnt_q              <= '0;
                            key_state_o        <= 1'b0;
                            key_released_stb_o <= 1'b1;
                        end else begin
                            state_q <= ST_CONF_RELEASE;
                            cnt_q   <= CNT_ONE;
                        end
                    end
`ifdef DEBOUNCER_MULTI_LONG_PRESS_EN
                    else begin
                        // Timer saturates at L; the done flag blocks re-firing after a bounce.
                        if (cnt_q != CNT_LONG) cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LONG - CNT_ONE && !long_done_q) begin
                            key_long_stb_o <= 1'b1;
                            long_done_q    <= 1'b1;
                        end
                    end
`endif
                end
                ST_CONF_RELEASE: begin
                    if (s) begin
                        state_q <= ST_PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_CONF) begin
                        state_q            <= ST_RELEASED;
                        cnt_q              <= '0;
                        key_state_o        <= 1'b0;
                        key_released_stb_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_RELEASED;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifndef DEBOUNCER_MULTI_LONG_PRESS_EN
    assign key_long_stb_o = 1'b0;
`endif

endmodule

// File: rtl/debouncer_multi.sv
// CHANNELS independent key debouncers with press/release strobes.
// Optional long-press strobe enabled by defining DEBOUNCER_MULTI_LONG_PRESS_EN.
module debouncer_multi
    import debouncer_pkg::*;
#(
    parameter int CLK_FREQ_MHZ   = 200,
    parameter int GLITCH_TIME_NS = 500,
    parameter int CHANNELS       = 4,
    parameter bit ACTIVE_LOW     = 1'b1,
    parameter int LONG_PRESS_NS  = 1000000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] key_i,
    output logic [CHANNELS-1:0] key_state_o,
    output logic [CHANNELS-1:0] key_pressed_stb_o,
    output logic [CHANNELS-1:0] key_released_stb_o,
    output logic [CHANNELS-1:0] key_long_stb_o
);

    localparam int G = cycles_from_ns(GLITCH_TIME_NS, CLK_FREQ_MHZ);
`ifdef DEBOUNCER_MULTI_LONG_PRESS_EN
    localparam int L     = cycles_from_ns(LONG_PRESS_NS, CLK_FREQ_MHZ);
    localparam int CNT_W = cnt_width((L > G) ? L : G);
`else
    localparam int CNT_W = cnt_width(G);
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debouncer_channel #(
            .G         (G),
            .CNT_W     (CNT_W),
`ifdef DEBOUNCER_MULTI_LONG_PRESS_EN
            .L         (L),
`endif
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_ch (
            .clk_i             (clk_i),
            .rst_i             (rst_i),
            .key_i             (key_i[i]),
            .key_state_o       (key_state_o[i]),
            .key_pressed_stb_o (key_pressed_stb_o[i]),
            .key_released_stb_o(key_released_stb_o[i]),
            .key_long_stb_o    (key_long_stb_o[i])
        );
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench: G=10 at 100 MHz, an active-low and an active-high instance side by side.
module tb_debouncer_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_a = 4'b1111;
    logic [3:0] key_b = 4'b0000;
    logic [3:0] state_a, pstb_a, rstb_a, lstb_a;
    logic [3:0] state_b, pstb_b, rstb_b, lstb_b;

    always #5 clk = ~clk;

    debouncer_multi #(
        .CLK_FREQ_MHZ(100), .GLITCH_TIME_NS(100), .CHANNELS(4),
        .ACTIVE_LOW(1'b1), .LONG_PRESS_NS(500)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .key_i(key_a),
        .key_state_o(state_a), .key_pressed_stb_o(pstb_a),
        .key_released_stb_o(rstb_a), .key_long_stb_o(lstb_a)
    );

    debouncer_multi #(
        .CLK_FREQ_MHZ(100), .GLITCH_TIME_NS(100), .CHANNELS(4),
        .ACTIVE_LOW(1'b0), .LONG_PRESS_NS(500)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .key_i(key_b),
        .key_state_o(state_b), .key_pressed_stb_o(pstb_b),
        .key_released_stb_o(rstb_b), .key_long_stb_o(lstb_b)
    );

    typedef struct {
        bit         on_b;
        logic [3:0] key;
        int         cycles;
        logic [3:0] exp_state;
        logic [3:0] exp_press;
        logic [3:0] exp_rel;
        int         exp_pidx;
        int         exp_ridx;
    } vec_t;

    vec_t vecs[17];
    int   n_total = 0;
    int   n_pass  = 0;
    int   pcnt[4], rcnt[4], lcnt[4], pidx[4], ridx[4], lidx[4];
    logic ovl;
    logic [3:0] st_now;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Called on a negedge; applies the key and samples outputs on each following negedge.
    task automatic run_step(input bit on_b, input logic [3:0] key, input int cycles);
        logic [3:0] ps, rs, ls;
        for (int c = 0; c < 4; c++) begin
            pcnt[c] = 0; rcnt[c] = 0; lcnt[c] = 0;
            pidx[c] = 0; ridx[c] = 0; lidx[c] = 0;
        end
        ovl = 1'b0;
        if (on_b) key_b = key; else key_a = key;
        for (int n = 1; n <= cycles; n++) begin
            @(negedge clk);
            ps = on_b ? pstb_b : pstb_a;
            rs = on_b ? rstb_b : rstb_a;
            ls = on_b ? lstb_b : lstb_a;
            for (int c = 0; c < 4; c++) begin
                if (ps[c]) begin pcnt[c]++; if (pidx[c] == 0) pidx[c] = n; end
                if (rs[c]) begin rcnt[c]++; if (ridx[c] == 0) ridx[c] = n; end
                if (ls[c]) begin lcnt[c]++; if (lidx[c] == 0) lidx[c] = n; end
            end
            if ((ps & rs) != 4'b0000) ovl = 1'b1;
        end
        st_now = on_b ? state_b : state_a;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          on_b  key      cyc state    press    rel      pidx ridx
        vecs[0]  = '{1'b0, 4'b1111,  5, 4'b0000, 4'b0000, 4'b0000,  0,  0};
        vecs[1]  = '{1'b0, 4'b1110, 20, 4'b0001, 4'b0001, 4'b0000, 12,  0};
        vecs[2]  = '{1'b0, 4'b1100,  9, 4'b0001, 4'b0000, 4'b0000,  0,  0};
        vecs[3]  = '{1'b0, 4'b1110, 15, 4'b0001, 4'b0000, 4'b0000,  0,  0};
        vecs[4]  = '{1'b0, 4'b1100, 10, 4'b0001, 4'b0000, 4'b0000,  0,  0};
        vecs[5]  = '{1'b0, 4'b1110, 15, 4'b0001, 4'b0010, 4'b0010,  2, 12};
        vecs[6]  = '{1'b0, 4'b1111,  7, 4'b0001, 4'b0000, 4'b0000,  0,  0};
        vecs[7]  = '{1'b0, 4'b1110,  5, 4'b0001, 4'b0000, 4'b0000,  0,  0};
        vecs[8]  = '{1'b0, 4'b1111, 20, 4'b0000, 4'b0000, 4'b0001,  0, 12};
        vecs[9]  = '{1'b0, 4'b0000, 15, 4'b1111, 4'b1111, 4'b0000, 12,  0};
        vecs[10] = '{1'b0, 4'b1111, 15, 4'b0000, 4'b0000, 4'b1111,  0, 12};
        vecs[11] = '{1'b0, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0000,  0,  0};
        vecs[12] = '{1'b0, 4'b1111, 15, 4'b0000, 4'b0000, 4'b0000,  0,  0};
        vecs[13] = '{1'b1, 4'b0101, 15, 4'b0101, 4'b0101, 4'b0000, 12,  0};
        vecs[14] = '{1'b1, 4'b0000, 15, 4'b0000, 4'b0000, 4'b0101,  0, 12};
        vecs[15] = '{1'b1, 4'b1000,  9, 4'b0000, 4'b0000, 4'b0000,  0,  0};
        vecs[16] = '{1'b1, 4'b0000, 15, 4'b0000, 4'b0000, 4'b0000,  0,  0};

        repeat (2) @(negedge clk);
        check("reset state_a", int'(state_a), 0);
        check("reset state_b", int'(state_b), 0);
        check("reset strobes_a", int'({pstb_a, rstb_a, lstb_a}), 0);
        check("reset strobes_b", int'({pstb_b, rstb_b, lstb_b}), 0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_step(vecs[i].on_b, vecs[i].key, vecs[i].cycles);
            check($sformatf("v%0d state", i), int'(st_now), int'(vecs[i].exp_state));
            check($sformatf("v%0d press/release overlap", i), int'(ovl), 0);
            for (int c = 0; c < 4; c++) begin
                check($sformatf("v%0d press count ch%0d", i, c), pcnt[c], int'(vecs[i].exp_press[c]));
                check($sformatf("v%0d release count ch%0d", i, c), rcnt[c], int'(vecs[i].exp_rel[c]));
                if (vecs[i].exp_press[c] && vecs[i].exp_pidx != 0)
                    check($sformatf("v%0d press cycle ch%0d", i, c), pidx[c], vecs[i].exp_pidx);
                if (vecs[i].exp_rel[c] && vecs[i].exp_ridx != 0)
                    check($sformatf("v%0d release cycle ch%0d", i, c), ridx[c], vecs[i].exp_ridx);
`ifndef DEBOUNCER_MULTI_LONG_PRESS_EN
                check($sformatf("v%0d long count ch%0d", i, c), lcnt[c], 0);
`endif
            end
        end

        // Async reset while ch2 is pressed and ch0 is at cnt=5 of confirmation.
        run_step(1'b0, 4'b1011, 14);
        check("pre-reset ch2 press", pcnt[2], 1);
        run_step(1'b0, 4'b1010, 7);
        check("pre-reset state", int'(state_a), 4'b0100);
        #2 rst = 1'b1;
        #1;
        check("async reset state", int'(state_a), 0);
        check("async reset strobes", int'({pstb_a, rstb_a}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_step(1'b0, 4'b1010, 20);
        check("post-reset press ch0", pcnt[0], 1);
        check("post-reset press ch2", pcnt[2], 1);
        check("post-reset press cycle ch0", pidx[0], 12);
        check("post-reset press cycle ch2", pidx[2], 12);
        check("post-reset releases", rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3], 0);
        check("post-reset state", int'(state_a), 4'b0101);
        run_step(1'b0, 4'b1111, 15);
        check("post-reset release ch0", rcnt[0], 1);
        check("post-reset final state", int'(state_a), 0);

        // Long hold on ch3.
        run_step(1'b0, 4'b0111, 200);
        check("long hold press ch3", pcnt[3], 1);
        check("long hold press cycle ch3", pidx[3], 12);
`ifdef DEBOUNCER_MULTI_LONG_PRESS_EN
        check("long strobe count ch3", lcnt[3], 1);
        check("long strobe cycle ch3", lidx[3], 62);
`else
        check("long strobe count ch3", lcnt[3], 0);
`endif
        run_step(1'b0, 4'b1111, 15);
        check("long hold release ch3", rcnt[3], 1);
        check("long hold final state", int'(state_a), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
- Next-generation debouncer with CHANNELS independent key inputs sharing one clock.
- Per channel: 2-FF synchroniser, symmetric press/release qualification FSM, debounced level, one-cycle press strobe and one-cycle release strobe.
- Configurable active polarity. Sits between board buttons/switches and control logic; replaces single-channel press-only debouncing.

Parameters:
- CLK_FREQ_MHZ, 200: clock frequency in MHz.
- GLITCH_TIME_NS, 500: minimum stable time for a level change to be accepted.
- CHANNELS, 4: number of independent key inputs (>=1).
- ACTIVE_LOW, 1: 1 = key_i low means pressed; 0 = key_i high means pressed.
- LONG_PRESS_NS, 1000000: long-press threshold. Used only with the optional feature.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset; asynchronous, active-high
- key_i  input  CHANNELS  raw asynchronous key levels
- key_state_o  output  CHANNELS  debounced level, 1 = pressed
- key_pressed_stb_o  output  CHANNELS  one-cycle pulse on accepted press
- key_released_stb_o  output  CHANNELS  one-cycle pulse on accepted release
- key_long_stb_o  output  CHANNELS  one-cycle pulse when long-press threshold is reached (optional feature)

Behaviour:
- Constants:
  - G = max(1, ceil(GLITCH_TIME_NS*CLK_FREQ_MHZ/1000)), computed in integer arithmetic, no reals.
  - Counter width = $clog2(max(G, L)+1), where L is the long-press cycle count.
- Sampling: s = second sync stage XOR ACTIVE_LOW; s=1 means pressed.
- FSM per channel, states RELEASED, CONF_PRESS, PRESSED, CONF_RELEASE:
  - RELEASED, s=1: G==1 -> go to PRESSED. Otherwise -> go to CONF_PRESS with cnt=1.
  - CONF_PRESS, s=0: return to RELEASED, cnt=0.
  - CONF_PRESS, s=1, cnt==G-1: go to PRESSED, cnt=0.
  - CONF_PRESS, s=1, otherwise: cnt++.
  - PRESSED and CONF_RELEASE mirror the above with s inverted.
- Outputs are registered:
  - key_state_o=1 in PRESSED and CONF_RELEASE.
  - key_pressed_stb_o pulses high for exactly one cycle, in the cycle key_state_o first reads 1.
  - key_released_stb_o pulses high for exactly one cycle, in the cycle key_state_o first reads 0.
- Latency: key_i captured pressed at edge k and stable -> strobe and state high after edge k+G+1.
- Glitches: a glitch shorter than G sampled cycles produces no strobe and no state change. A glitch mid-confirmation restarts qualification from zero.
- Press and release strobes of one channel are never high in the same cycle. At least G cycles separate them.
- Channels are fully independent; simultaneous events on different channels each produce their own strobe.
- Reset (rst_i, asynchronous):
  - Sync flops load the released level (~ACTIVE_LOW).
  - FSM goes to RELEASED; counters 0; all outputs 0.
- Deassertion with key held pressed: full qualification, then a press strobe (no strobe lost, none duplicated).
- Reset mid-confirmation or mid-press aborts silently; no release strobe.
- Counter never wraps; it saturates at its terminal value.

Optional Feature:
- Macro: DEBOUNCER_MULTI_LONG_PRESS_EN.
- Defined:
  - L = ceil(LONG_PRESS_NS*CLK_FREQ_MHZ/1000).
  - In PRESSED, cnt counts cycles since acceptance. When cnt reaches L, key_long_stb_o pulses once; cnt then saturates.
  - At most one long strobe per press. Entering CONF_RELEASE does not clear the long-press flag; a return to PRESSED from CONF_RELEASE does not re-fire.
- Undefined: key_long_stb_o is tied to 0 and no long-press logic is synthesised. Counter width uses G only.

Decomposition:
- Package debouncer_pkg:
  - FSM state enum.
  - Integer function cycles_from_ns(ns, mhz) with max(1,·) clamp.
  - Width helper.
- Sub-module debouncer_channel holds one synchroniser, FSM, counter and output registers. debouncer_multi generates CHANNELS instances.

Test Plan:
- Params CLK_FREQ_MHZ=100, GLITCH_TIME_NS=100 (G=10), ACTIVE_LOW=1; hold key_i[0]=0 -> key_pressed_stb_o[0] high for exactly 1 cycle, 12 edges after first capture edge; key_state_o[0]=1.
- Same params; 9-cycle low glitch on key_i[1] -> no strobes; state stays 0. Then 10-cycle low -> one press strobe.
- Release after press: key_i[0]=1 for 10 cycles -> one key_released_stb_o[0] pulse; 5-cycle bounce inside restarts count (strobe 10 cycles after last bounce).
- Simultaneous press on all 4 channels -> 4 press strobes in the same cycle. ACTIVE_LOW=0 run: key_i high = press.
- Assert rst_i asynchronously at cnt=5 during CONF_PRESS -> outputs 0 immediately. Key still held after release of reset -> press strobe 12 edges later.
- With DEBOUNCER_MULTI_LONG_PRESS_EN, LONG_PRESS_NS=500 (L=50): hold 200 cycles -> exactly one key_long_stb_o pulse, 50 cycles after press strobe. Without macro -> key_long_stb_o constant 0.
